instruction_controller: RTL and testbench

Upstream control stage for the computation datapath: latches a 16-bit instruction, decodes it, and sequences the register file, operand loads, shifter, ALU, and the C/status load enables through a Moore FSM. Everything the computation stage consumes (`shift`, `ALUop`, `asel`, `bsel`, `loadc`, `loads`) and the register-file controls (`readnum`, `writenum`, `write`, `vsel`, `loada`, `loadb`) originate here. It also supplies the sign-extended immediates used on the B and writeback paths.

---
 rtl/instruction_controller_if.sv | 35 +++
 rtl/instruction_controller.sv | 139 +++++++++++++
 tb/tb_instruction_controller.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/instruction_controller_if.sv
// Instruction-issue / datapath-control bundle between the host stage and instruction_controller.
// The controller takes the slave side; whoever supplies instructions takes the master side.
interface instruction_controller_if;
  logic        s;
  logic        load;
  logic [15:0] in;
  logic        w;
  logic        illegal;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        vsel;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm5;
  logic [15:0] sximm8;

  modport master (
    output s, load, in,
    input  w, illegal, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
           asel, bsel, shift, ALUop, sximm5, sximm8
  );

  modport slave (
    input  s, load, in,
    output w, illegal, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
           asel, bsel, shift, ALUop, sximm5, sximm8
  );
endinterface

// File: rtl/instruction_controller.sv
// Instruction register, decoder and Moore sequencer driving the register file and ALU stage.
// Control outputs are registered from the next state/IR so they are glitch-free Moore values.
module instruction_controller (
  input  logic                      clk,
  input  logic                      reset,
  instruction_controller_if.slave   bus
);

  typedef enum logic [2:0] {
    WAIT      = 3'd0,
    DECODE    = 3'd1,
    WRITE_IMM = 3'd2,
    GET_A     = 3'd3,
    GET_B     = 3'd4,
    ALU       = 3'd5,
    WRITE_REG = 3'd6
  } state_t;

  typedef struct packed {
    logic       w;
    logic       illegal;
    logic       write;
    logic       vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] shift;
    logic [1:0] aluop;
    logic [2:0] readnum;
    logic [2:0] writenum;
  } ctl_t;

  state_t      state, state_nxt;
  logic [15:0] ir, ir_nxt;
  ctl_t        ctl;

  function automatic logic is_legal(input logic [15:0] i);
    case ({i[15:13], i[12:11]})
      5'b110_10, 5'b110_00,
      5'b101_00, 5'b101_01, 5'b101_10, 5'b101_11: is_legal = 1'b1;
      default:                                    is_legal = 1'b0;
    endcase
  endfunction

  function automatic ctl_t decode(input state_t st, input logic [15:0] i);
    ctl_t c;
    c = '0;
    case (st)
      WAIT:      c.w = 1'b1;
      DECODE:    c.illegal = !is_legal(i);
      WRITE_IMM: begin
        c.write    = 1'b1;
        c.vsel     = 1'b1;
        c.writenum = i[10:8];
      end
      GET_A: begin
        c.loada   = 1'b1;
        c.readnum = i[10:8];
      end
      GET_B: begin
        c.loadb   = 1'b1;
        c.readnum = i[2:0];
      end
      ALU: begin
        c.shift = i[4:3];
        // MOV reg passes B straight through, so the ALU is forced to ADD with A zeroed
        c.aluop = (i[15:13] == 3'b110) ? 2'b00 : i[12:11];
        c.asel  = (i[15:13] == 3'b101) && (i[12:11] != 2'b11);
        if ((i[15:13] == 3'b101) && (i[12:11] == 2'b01)) c.loads = 1'b1;
        else                                             c.loadc = 1'b1;
      end
      WRITE_REG: begin
        c.write    = 1'b1;
        c.writenum = i[7:5];
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_nxt = state;
    ir_nxt    = ir;
    case (state)
      WAIT: begin
        if (bus.load) ir_nxt = bus.in;
        if (bus.s)    state_nxt = DECODE;
      end
      DECODE: begin
        if (!is_legal(ir))                                    state_nxt = WAIT;
        else if (ir[15:13] == 3'b110 && ir[12:11] == 2'b10)   state_nxt = WRITE_IMM;
        else if (ir[15:13] == 3'b110 || ir[12:11] == 2'b11)   state_nxt = GET_B;
        else                                                  state_nxt = GET_A;
      end
      WRITE_IMM: state_nxt = WAIT;
      GET_A:     state_nxt = GET_B;
      GET_B:     state_nxt = ALU;
      ALU: begin
        if (ir[15:13] == 3'b101 && ir[12:11] == 2'b01) state_nxt = WAIT;
        else                                           state_nxt = WRITE_REG;
      end
      WRITE_REG: state_nxt = WAIT;
      default:   state_nxt = WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT;
      ir    <= '0;
      ctl   <= decode(WAIT, 16'h0000);
    end else begin
      state <= state_nxt;
      ir    <= ir_nxt;
      ctl   <= decode(state_nxt, ir_nxt);
    end
  end

  assign bus.w        = ctl.w;
  assign bus.illegal  = ctl.illegal;
  assign bus.write    = ctl.write;
  assign bus.vsel     = ctl.vsel;
  assign bus.loada    = ctl.loada;
  assign bus.loadb    = ctl.loadb;
  assign bus.loadc    = ctl.loadc;
  assign bus.loads    = ctl.loads;
  assign bus.asel     = ctl.asel;
  assign bus.bsel     = ctl.bsel;
  assign bus.shift    = ctl.shift;
  assign bus.ALUop    = ctl.aluop;
  assign bus.readnum  = ctl.readnum;
  assign bus.writenum = ctl.writenum;
  assign bus.sximm5   = {{11{ir[4]}}, ir[4:0]};
  assign bus.sximm8   = {{8{ir[7]}}, ir[7:0]};

endmodule

// File: tb/tb_instruction_controller.sv
// Directed bench for instruction_controller: walks each instruction class state by state.
module tb_instruction_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instruction_controller_if bus ();

  instruction_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cur();
    return {12'h000, bus.w, bus.illegal, bus.write, bus.vsel, bus.loada, bus.loadb,
            bus.loadc, bus.loads, bus.asel, bus.bsel, bus.shift, bus.ALUop,
            bus.readnum, bus.writenum};
  endfunction

  // Expected control word: w ill wr vsel la lb lc ls asel bsel shift aluop readnum writenum
  function automatic logic [31:0] mk(input int w, input int il, input int wr, input int vs,
                                     input int la, input int lb, input int lc, input int ls,
                                     input int as, input int bs, input int sh, input int op,
                                     input int rn, input int wn);
    return {12'h000, w[0], il[0], wr[0], vs[0], la[0], lb[0], lc[0], ls[0], as[0], bs[0],
            sh[1:0], op[1:0], rn[2:0], wn[2:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] idle, none;

  initial begin
    idle = mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0);
    none = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    reset = 1'b1; bus.s = 1'b0; bus.load = 1'b0; bus.in = 16'h0000;
    tick(); tick();
    reset = 1'b0;
    chk("reset_ctl", cur(), idle);
    chk("reset_imm", {bus.sximm5, bus.sximm8}, 32'h0000_0000);
    repeat (10) tick();
    chk("idle_10", cur(), idle);

    // MOV R1,#-10 with load and s together
    bus.in = 16'hD1F6; bus.load = 1'b1; bus.s = 1'b1;
    tick();
    bus.load = 1'b0; bus.s = 1'b0;
    chk("movi_decode", cur(), none);
    chk("movi_imm", {bus.sximm5, bus.sximm8}, 32'hFFF6_FFF6);
    tick();
    chk("movi_write", cur(), mk(0,0,1,1,0,0,0,0,0,0,0,0,0,1));
    tick();
    chk("movi_done", cur(), idle);

    // ADD R5,R2,R3: IR loaded first, started later; load pulse mid-instruction is ignored
    bus.in = 16'hA2A3; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    chk("add_loaded_wait", cur(), idle);
    bus.s = 1'b1;
    tick();
    bus.s = 1'b0;
    chk("add_decode", cur(), none);
    bus.in = 16'hFFFF; bus.load = 1'b1;
    tick();
    chk("add_geta", cur(), mk(0,0,0,0,1,0,0,0,0,0,0,0,2,0));
    tick();
    bus.load = 1'b0;
    chk("add_getb", cur(), mk(0,0,0,0,0,1,0,0,0,0,0,0,3,0));
    tick();
    chk("add_alu", cur(), mk(0,0,0,0,0,0,1,0,1,0,0,0,0,0));
    tick();
    chk("add_wreg", cur(), mk(0,0,1,0,0,0,0,0,0,0,0,0,0,5));
    chk("add_ir_kept", {bus.sximm5, bus.sximm8}, 32'h0003_FFA3);
    tick();
    chk("add_done", cur(), idle);

    // CMP R1,R2 LSL-style sh=01
    bus.in = 16'hA90A; bus.load = 1'b1; bus.s = 1'b1;
    tick();
    bus.load = 1'b0; bus.s = 1'b0;
    chk("cmp_imm", {bus.sximm5, bus.sximm8}, 32'h000A_000A);
    tick();
    chk("cmp_geta", cur(), mk(0,0,0,0,1,0,0,0,0,0,0,0,1,0));
    tick();
    chk("cmp_getb", cur(), mk(0,0,0,0,0,1,0,0,0,0,0,0,2,0));
    tick();
    chk("cmp_alu", cur(), mk(0,0,0,0,0,0,0,1,1,0,1,1,0,0));
    tick();
    chk("cmp_done", cur(), idle);

    // MVN R7,R4
    bus.in = 16'hB8E4; bus.load = 1'b1; bus.s = 1'b1;
    tick();
    bus.load = 1'b0; bus.s = 1'b0;
    chk("mvn_decode", cur(), none);
    tick();
    chk("mvn_getb", cur(), mk(0,0,0,0,0,1,0,0,0,0,0,0,4,0));
    tick();
    chk("mvn_alu", cur(), mk(0,0,0,0,0,0,1,0,0,0,0,3,0,0));
    tick();
    chk("mvn_wreg", cur(), mk(0,0,1,0,0,0,0,0,0,0,0,0,0,7));
    tick();
    chk("mvn_done", cur(), idle);

    // MOV R3,R5 with sh=10: ALUop forced to 00, A zeroed
    bus.in = 16'hC075; bus.load = 1'b1; bus.s = 1'b1;
    tick();
    bus.load = 1'b0; bus.s = 1'b0;
    tick();
    chk("movr_getb", cur(), mk(0,0,0,0,0,1,0,0,0,0,0,0,5,0));
    tick();
    chk("movr_alu", cur(), mk(0,0,0,0,0,0,1,0,0,0,2,0,0,0));
    tick();
    chk("movr_wreg", cur(), mk(0,0,1,0,0,0,0,0,0,0,0,0,0,3));
    tick();
    chk("movr_done", cur(), idle);

    // Illegal encoding
    bus.in = 16'hE000; bus.load = 1'b1; bus.s = 1'b1;
    tick();
    bus.load = 1'b0; bus.s = 1'b0;
    chk("ill_pulse", cur(), mk(0,1,0,0,0,0,0,0,0,0,0,0,0,0));
    tick();
    chk("ill_done", cur(), idle);

    // Reset during GET_B of an ADD
    bus.in = 16'hA2A3; bus.load = 1'b1; bus.s = 1'b1;
    tick();
    bus.load = 1'b0; bus.s = 1'b0;
    tick(); tick();
    chk("rst_getb", cur(), mk(0,0,0,0,0,1,0,0,0,0,0,0,3,0));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_ctl", cur(), idle);
    chk("rst_mid_ir", {bus.sximm5, bus.sximm8}, 32'h0000_0000);
    tick();
    chk("rst_mid_stay", cur(), idle);

    // s held high: exactly one WAIT cycle between instructions
    bus.in = 16'hD1F6; bus.load = 1'b1; bus.s = 1'b1;
    tick();
    bus.load = 1'b0;
    tick();
    chk("sh_write", cur(), mk(0,0,1,1,0,0,0,0,0,0,0,0,0,1));
    tick();
    chk("sh_wait", cur(), idle);
    tick();
    chk("sh_restart", cur(), none);

    // Reset wins over s and load
    bus.in = 16'hFFFF; bus.load = 1'b1; bus.s = 1'b1; reset = 1'b1;
    tick();
    chk("rst_prio_ctl", cur(), idle);
    chk("rst_prio_ir", {bus.sximm5, bus.sximm8}, 32'h0000_0000);
    reset = 1'b0; bus.load = 1'b0; bus.s = 1'b0;
    tick();
    chk("rst_prio_after", cur(), idle);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
